// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state and data-source encodings for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_JEDEC     = 8'h9F;
  localparam logic [7:0] OP_STATUS    = 8'h05;
  localparam logic [7:0] OP_PD        = 8'hB9;
  localparam logic [7:0] OP_RPD       = 8'hAB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM    = 2'd0,
    SRC_ID     = 2'd1,
    SRC_STATUS = 2'd2
  } src_t;

  // JEDEC bytes go out MSB byte first, then 0xFF forever.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      2'd2:    b = id[7:0];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for cs/sck/mosi plus single-cycle sck edge pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sck,
  input  logic mosi,
  output logic cs_sync,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall
);

  logic [2:0] meta;
  logic [2:0] sync;
  logic       sck_prev;

  // cs resets high so the responder starts deselected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= 3'b100;
      sync     <= 3'b100;
      sck_prev <= 1'b0;
    end else begin
      meta     <= {cs, sck, mosi};
      sync     <= meta;
      sck_prev <= sync[1];
    end
  end

  assign cs_sync   = sync[2];
  assign mosi_sync = sync[0];
  assign sck_rise  = sync[1] & ~sck_prev;
  assign sck_fall  = ~sync[1] & sck_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: decodes read/fast-read/JEDEC/status/power commands
// and streams read data fetched one byte ahead over a byte-wide memory port.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 24,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_cs,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 mem_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 powered_down,
  output logic                 underrun,
  output logic [7:0]           last_cmd
);

  logic        cs_sync, mosi_sync, sck_rise, sck_fall;
  state_t      state;
  src_t        src;
  logic [4:0]  bit_cnt;
  logic [7:0]  shift_in;
  logic [23:0] addr_shift;
  logic [7:0]  out_shift;
  logic [7:0]  data_buf;
  logic [1:0]  id_idx;
  logic        fast_read, boundary, start_req, have_byte, pd_pending, pu_pending;
  logic [7:0]  opcode;
  logic [23:0] addr_full;
  logic [7:0]  next_byte;

  spi_pin_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .cs        (spi_cs),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .cs_sync   (cs_sync),
    .mosi_sync (mosi_sync),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall)
  );

  assign opcode    = {shift_in[6:0], mosi_sync};
  assign addr_full = {addr_shift[22:0], mosi_sync};

  // Byte presented at the next data boundary
  always_comb begin
    next_byte = 8'hFF;
    case (src)
      SRC_MEM:    next_byte = have_byte ? data_buf : 8'hFF;
      SRC_ID:     next_byte = id_byte(JEDEC_ID, id_idx);
      SRC_STATUS: next_byte = 8'h00;
      default:    next_byte = 8'hFF;
    endcase
  end

  // Command FSM, memory prefetch and serial output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      src          <= SRC_MEM;
      bit_cnt      <= 5'd0;
      shift_in     <= 8'h00;
      addr_shift   <= 24'h000000;
      out_shift    <= 8'hFF;
      data_buf     <= 8'h00;
      id_idx       <= 2'd0;
      fast_read    <= 1'b0;
      boundary     <= 1'b0;
      start_req    <= 1'b0;
      have_byte    <= 1'b0;
      pd_pending   <= 1'b0;
      pu_pending   <= 1'b0;
      spi_miso     <= 1'b1;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      powered_down <= 1'b0;
      underrun     <= 1'b0;
      last_cmd     <= 8'h00;
    end else if (cs_sync) begin
      state      <= ST_IDLE;
      spi_miso   <= 1'b1;
      mem_req    <= 1'b0;
      start_req  <= 1'b0;
      have_byte  <= 1'b0;
      boundary   <= 1'b0;
      pd_pending <= 1'b0;
      pu_pending <= 1'b0;
      if (pd_pending) begin
        powered_down <= 1'b1;
      end else if (pu_pending) begin
        powered_down <= 1'b0;
      end
    end else begin
      if (mem_req && mem_ack) begin
        data_buf  <= mem_rdata;
        have_byte <= 1'b1;
        mem_req   <= 1'b0;
      end
      if (start_req) begin
        mem_req   <= 1'b1;
        start_req <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          state   <= ST_CMD;
          bit_cnt <= 5'd0;
        end
        ST_CMD: if (sck_rise) begin
          shift_in <= opcode;
          bit_cnt  <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            last_cmd <= opcode;
            bit_cnt  <= 5'd0;
            if (powered_down && opcode != OP_RPD) begin
              state <= ST_IGNORE;
            end else begin
              case (opcode)
                OP_READ:      begin state <= ST_ADDR; fast_read <= 1'b0; end
                OP_FAST_READ: begin state <= ST_ADDR; fast_read <= 1'b1; end
                OP_JEDEC:     begin state <= ST_DATA; src <= SRC_ID; id_idx <= 2'd0; boundary <= 1'b1; end
                OP_STATUS:    begin state <= ST_DATA; src <= SRC_STATUS; boundary <= 1'b1; end
                OP_PD:        begin state <= ST_IGNORE; pd_pending <= 1'b1; end
                OP_RPD:       begin state <= ST_IGNORE; pu_pending <= 1'b1; end
                default:      state <= ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: if (sck_rise) begin
          addr_shift <= addr_full;
          bit_cnt    <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd23) begin
            mem_addr  <= addr_full[ADDR_BITS-1:0];
            start_req <= 1'b1;
            have_byte <= 1'b0;
            src       <= SRC_MEM;
            bit_cnt   <= 5'd0;
            if (fast_read) begin
              state <= ST_DUMMY;
            end else begin
              state    <= ST_DATA;
              boundary <= 1'b1;
            end
          end
        end
        ST_DUMMY: if (sck_rise) begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt  <= 5'd0;
            state    <= ST_DATA;
            boundary <= 1'b1;
          end
        end
        ST_DATA: begin
          if (sck_rise) begin
            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              boundary <= 1'b1;
            end
          end
          if (sck_fall) begin
            if (boundary) begin
              boundary  <= 1'b0;
              spi_miso  <= next_byte[7];
              out_shift <= {next_byte[6:0], 1'b1};
              if (src == SRC_ID && id_idx != 2'd3) begin
                id_idx <= id_idx + 2'd1;
              end
              // A consumed byte advances the address and launches the next prefetch
              if (src == SRC_MEM) begin
                if (have_byte) begin
                  have_byte <= 1'b0;
                  mem_addr  <= mem_addr + ADDR_BITS'(1);
                  mem_req   <= 1'b1;
                end else begin
                  underrun <= 1'b1;
                end
              end
            end else begin
              spi_miso  <= out_shift[7];
              out_shift <= {out_shift[6:0], 1'b1};
            end
          end
        end
        ST_IGNORE: spi_miso <= 1'b1;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI-mode-0 flash responder: the flash-side counterpart to the bootloader's SPI master (spi_cs/spi_sck/spi_mosi/spi_miso).
- Oversamples the SPI pins on the system clock, decodes a minimal command set and serves read data from a byte-wide memory request port.
- Used as a synthesizable flash stand-in for boards or emulation, and as the self-checking flash model in bootloader benches.

Parameters:
- ADDR_BITS, 24, width of flash byte address; address counter wraps modulo 2^ADDR_BITS.
- JEDEC_ID, 24'hEF4016, bytes returned by 0x9F, MSB byte first.

Ports:
- clk  in  1  system clock; SCK must be at most clk/8.
- reset  in  1  asynchronous, active-high reset.
- spi_cs  in  1  chip select, active low.
- spi_sck  in  1  serial clock, idle low (mode 0).
- spi_mosi  in  1  serial data in, sampled on rising SCK.
- spi_miso  out  1  serial data out, changes after falling SCK.
- mem_req  out  1  read request, held until mem_ack.
- mem_addr  out  ADDR_BITS  byte address for the request.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  8  read data.
- powered_down  out  1  deep power-down state.
- underrun  out  1  sticky: data byte was needed before mem_ack; cleared only by reset.
- last_cmd  out  8  last complete opcode received.

Behaviour:
- Reset values: spi_miso=1, mem_req=0, mem_addr=0, powered_down=0, underrun=0, last_cmd=0, FSM=IDLE.
- Pin sampling:
  - cs, sck and mosi each pass through 2-flop synchronizers.
  - A registered copy of the synchronized sck gives rise and fall pulses.
  - A rise pulse shifts in mosi, MSB first.
  - spi_miso updates exactly 3 clk after the pin-level falling edge of SCK.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
  - IDLE -> CMD on synchronized cs low. Bit counter is cleared.
  - CMD, after 8 rising edges: latch last_cmd, then decode the opcode:
    - 0x03 -> ADDR.
    - 0x0B -> ADDR, then DUMMY.
    - 0x9F -> DATA with source ID.
    - 0x05 -> DATA with source STATUS.
    - 0xB9 -> IGNORE, with power-down pending.
    - 0xAB -> IGNORE, with power-up pending.
    - Any other opcode -> IGNORE.
  - While powered_down=1, every opcode except 0xAB goes to IGNORE and spi_miso stays 1.
  - ADDR: collect 3 address bytes, MSB first; the upper bits beyond ADDR_BITS are discarded.
    - After the 24th rising edge, mem_addr is loaded and mem_req asserts on the next cycle.
    - Next state is DUMMY for 0x0B, otherwise DATA.
  - DUMMY: 8 rising edges, then DATA; spi_miso=1 throughout.
  - DATA byte boundary = the falling edge after each 8th rising edge, including the one ending the last command/address/dummy bit.
    - At each boundary the shift register loads the next byte and spi_miso takes its MSB.
    - Source MEM: prefetched byte. If no mem_ack has arrived yet, load 0xFF and set underrun.
    - Source ID: JEDEC bytes 2, 1, 0, then 0xFF forever.
    - Source STATUS: 0x00 forever.
  - MEM prefetch:
    - On mem_ack, capture mem_rdata and drop mem_req.
    - At the boundary that consumes the byte, increment mem_addr (2^ADDR_BITS-1 wraps to 0) and re-assert mem_req.
    - Only one request is outstanding at a time.
  - IGNORE: spi_miso=1 until cs rises.
- CS deassertion (synchronized cs high) from any state:
  - FSM goes to IDLE and spi_miso=1 next cycle.
  - mem_req drops the same cycle; a late mem_ack is ignored.
  - Pending power-down/power-up is applied on that cycle.
  - A partial opcode (fewer than 8 bits) leaves last_cmd and powered_down unchanged.
- Rise and fall pulses while cs is high are ignored.
- Reset asserted mid-transaction returns all state to reset values immediately.

Decomposition:
- Package spi_flash_pkg: opcode localparams (OP_READ=8'h03, OP_FAST_READ=8'h0B, OP_JEDEC=8'h9F, OP_STATUS=8'h05, OP_PD=8'hB9, OP_RPD=8'hAB), FSM state encoding, data-source encoding.
- Sub-module spi_pin_sync: 3-bit 2-flop synchronizer plus sck rise/fall pulse and synchronized cs output; reused by other SPI-facing blocks.

Test Plan:
- 0x9F then 5 bytes at SCK=clk/8 -> MISO reads EF 40 16 FF FF; last_cmd=0x9F.
- 0x03, addr 000010, read 4 bytes, memory model acking in 1 clk -> MISO reads mem[0x10..0x13]; mem_addr requests 10,11,12,13,14; underrun=0.
- 0x0B, addr FFFFFE, dummy byte, read 3 bytes -> bytes from FFFFFE, FFFFFF, 000000 (wrap); spi_miso=1 during the dummy byte.
- 0xB9 with CS high; then 0x9F -> powered_down=1, MISO all 1s. Then 0xAB with CS high; then 0x9F -> powered_down=0, reads EF 40 16.
- 0x03, addr 000000, memory model withholds mem_ack -> first data byte FF, underrun=1. CS high mid-second byte -> mem_req=0 within 3 clk and FSM idle. A later ack has no effect.
- CS raised after 5 bits of 0xB9 -> powered_down stays 0 and last_cmd unchanged. Reset asserted mid-read -> all outputs return to reset values asynchronously.
